// File: rtl/music_box_pkg.sv
// ---------------------------------------------------------------------------
// music_box_pkg
// Shared types and constants for the music box mode arbiter.
//   arb_state_t  : arbiter FSM states (IDLE -> ACTIVE -> HOLDOFF -> IDLE)
//   SDRAM_ADDR_W : width of the SDRAM controller address port
//   SDRAM_DATA_W : width of the SDRAM controller write-data port
// ---------------------------------------------------------------------------
package music_box_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ACTIVE  = 2'd1,
        ARB_HOLDOFF = 2'd2
    } arb_state_t;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

endpackage

// File: rtl/music_box_audio_mixer.sv
// ---------------------------------------------------------------------------
// music_box_audio_mixer
// Masked, saturating, registered sum of the per-mode audio samples.
// A channel contributes when its mode is enabled or its PASSTHRU_MASK bit is
// set. The sum is formed wide enough that it can never wrap, then clamped to
// the full-scale AUDIO_W value.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous, active-high reset (clears the output to 0)
//   enable_i  : one-hot run enables from the arbiter
//   audio_i   : packed samples, slot k at [k*AUDIO_W +: AUDIO_W]
//   audio_o   : registered, clamped mix (one cycle after the inputs)
// ---------------------------------------------------------------------------
module music_box_audio_mixer #(
    parameter int                   NUM_MODES     = 4,
    parameter int                   AUDIO_W       = 8,
    parameter logic [NUM_MODES-1:0] PASSTHRU_MASK = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_MODES-1:0]         enable_i,
    input  logic [NUM_MODES*AUDIO_W-1:0] audio_i,
    output logic [AUDIO_W-1:0]           audio_o
);

    localparam int SUM_W = AUDIO_W + $clog2(NUM_MODES) + 1;

    logic [SUM_W-1:0]   sum;
    logic [AUDIO_W-1:0] audio_d;
    logic [AUDIO_W-1:0] audio_q;

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (enable_i[k] || PASSTHRU_MASK[k]) begin
                sum = sum + SUM_W'(audio_i[k*AUDIO_W +: AUDIO_W]);
            end
        end
        // Any bit above the sample width means the mix exceeds full scale.
        if (|sum[SUM_W-1:AUDIO_W]) begin
            audio_d = '1;
        end else begin
            audio_d = sum[AUDIO_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            audio_q <= '0;
        end else begin
            audio_q <= audio_d;
        end
    end

    assign audio_o = audio_q;

endmodule

// File: rtl/music_box_mode_arbiter.sv
// ---------------------------------------------------------------------------
// music_box_mode_arbiter
// Grants one of NUM_MODES button-requested modes at a time, holds off for
// HOLDOFF_CYCLES after each mode finishes, routes the single SDRAM command
// port to the active mode (when it is an SDRAM owner) and drives a saturating
// audio mix to the DAC.
//
// Optional feature: define MUSICBOX_MODE_TIMEOUT_EN to compile in an ACTIVE
// watchdog. After TIMEOUT_CYCLES ACTIVE cycles without mode_done the arbiter
// goes to HOLDOFF and pulses mode_timeout for one cycle. Without the macro
// there is no counter and mode_timeout is constant 0.
//
// Ports:
//   clock_50Mhz        : sole clock
//   reset              : synchronous, active-high
//   request_n          : debounced buttons, active-low level
//   mode_done          : per-mode completion; only the active mode's bit counts
//   current_mode       : 0 = none, k+1 = mode k active
//   mode_enable        : one-hot run enable (only in ACTIVE)
//   in_holdoff         : high during HOLDOFF
//   mode_timeout       : one-cycle watchdog pulse (first HOLDOFF cycle)
//   mode_audio         : packed per-mode samples
//   audio_out          : registered clamped mix
//   ch_*               : per-mode SDRAM command channels
//   sdram_*            : registered SDRAM command to the controller
//   dbg_state_o        : arbiter FSM state for observation
//
// Handshake: sdram_inputValid is a registered copy of the owning channel's
// ch_valid; it is qualified only by the arbiter grant, there is no ready.
// ---------------------------------------------------------------------------
module music_box_mode_arbiter
    import music_box_pkg::*;
#(
    parameter int                   NUM_MODES        = 4,
    parameter int                   AUDIO_W          = 8,
    parameter int                   HOLDOFF_CYCLES   = 33,
    parameter int                   REQUIRE_RELEASE  = 1,
    parameter logic [NUM_MODES-1:0] SDRAM_OWNER_MASK = NUM_MODES'(4'b1100),
    parameter logic [NUM_MODES-1:0] PASSTHRU_MASK    = '0,
    parameter int                   TIMEOUT_CYCLES   = 50_000_000
) (
    input  logic                              clock_50Mhz,
    input  logic                              reset,
    input  logic [NUM_MODES-1:0]              request_n,
    input  logic [NUM_MODES-1:0]              mode_done,
    output logic [$clog2(NUM_MODES+1)-1:0]    current_mode,
    output logic [NUM_MODES-1:0]              mode_enable,
    output logic                              in_holdoff,
    output logic                              mode_timeout,
    input  logic [NUM_MODES*AUDIO_W-1:0]      mode_audio,
    output logic [AUDIO_W-1:0]                audio_out,
    input  logic [NUM_MODES*SDRAM_ADDR_W-1:0] ch_addr,
    input  logic [NUM_MODES*SDRAM_DATA_W-1:0] ch_wdata,
    input  logic [NUM_MODES-1:0]              ch_is_writing,
    input  logic [NUM_MODES-1:0]              ch_valid,
    output logic [SDRAM_ADDR_W-1:0]           sdram_inputAddress,
    output logic [SDRAM_DATA_W-1:0]           sdram_writeData,
    output logic                              sdram_isWriting,
    output logic                              sdram_inputValid,
    output arb_state_t                        dbg_state_o
);

    localparam int MODE_W = $clog2(NUM_MODES + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    arb_state_t           state_q, state_d;
    logic [MODE_W-1:0]    grant_q, grant_d;
    logic [NUM_MODES-1:0] armed_q, armed_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

    logic [SDRAM_ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [SDRAM_DATA_W-1:0] sd_wdata_q, sd_wdata_d;
    logic                    sd_wr_q, sd_wr_d;
    logic                    sd_valid_q, sd_valid_d;

    logic [NUM_MODES-1:0] eligible;
    logic [MODE_W-1:0]    sel_idx;
    logic                 grant_fire;
    logic                 done_sel;

`ifdef MUSICBOX_MODE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] act_cnt_q, act_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Grant selection: highest-index eligible request wins.
    always_comb begin
        if (REQUIRE_RELEASE != 0) begin
            eligible = ~request_n & armed_q;
        end else begin
            eligible = ~request_n;
        end
        sel_idx  = '0;
        done_sel = 1'b0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (eligible[k]) begin
                sel_idx = MODE_W'(k);
            end
            if (grant_q == MODE_W'(k)) begin
                done_sel = mode_done[k];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        grant_fire = 1'b0;
`ifdef MUSICBOX_MODE_TIMEOUT_EN
        act_cnt_d  = act_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|eligible) begin
                    state_d    = ARB_ACTIVE;
                    grant_d    = sel_idx;
                    grant_fire = 1'b1;
`ifdef MUSICBOX_MODE_TIMEOUT_EN
                    act_cnt_d  = '0;
`endif
                end
            end
            ARB_ACTIVE: begin
                if (done_sel) begin
                    state_d    = ARB_HOLDOFF;
                    hold_cnt_d = '0;
`ifdef MUSICBOX_MODE_TIMEOUT_EN
                // Done has priority over a watchdog expiry in the same cycle.
                end else if (act_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ARB_HOLDOFF;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    act_cnt_d  = act_cnt_q + 1'b1;
`endif
                end
            end
            ARB_HOLDOFF: begin
                if (hold_cnt_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
                    state_d    = ARB_IDLE;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // A released button re-arms its mode; the granted mode is disarmed.
        // The granted button is low, so the two never touch the same bit.
        armed_d = armed_q | request_n;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (grant_fire && (sel_idx == MODE_W'(k))) begin
                armed_d[k] = 1'b0;
            end
        end
    end

    // SDRAM command mux, registered below.
    always_comb begin
        sd_addr_d  = '0;
        sd_wdata_d = '0;
        sd_wr_d    = 1'b0;
        sd_valid_d = 1'b0;
        if (state_q == ARB_ACTIVE) begin
            for (int k = 0; k < NUM_MODES; k++) begin
                if ((grant_q == MODE_W'(k)) && SDRAM_OWNER_MASK[k]) begin
                    sd_addr_d  = ch_addr[k*SDRAM_ADDR_W +: SDRAM_ADDR_W];
                    sd_wdata_d = ch_wdata[k*SDRAM_DATA_W +: SDRAM_DATA_W];
                    sd_wr_d    = ch_is_writing[k];
                    sd_valid_d = ch_valid[k];
                end
            end
        end
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            armed_q    <= '1;
            hold_cnt_q <= '0;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            sd_wr_q    <= 1'b0;
            sd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            armed_q    <= armed_d;
            hold_cnt_q <= hold_cnt_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            sd_wr_q    <= sd_wr_d;
            sd_valid_q <= sd_valid_d;
        end
    end

`ifdef MUSICBOX_MODE_TIMEOUT_EN
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            act_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            act_cnt_q <= act_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mode_timeout = timeout_q;
`else
    assign mode_timeout = 1'b0;
`endif

    // Outputs decoded from the registered state.
    always_comb begin
        mode_enable = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            mode_enable[k] = (state_q == ARB_ACTIVE) && (grant_q == MODE_W'(k));
        end
    end

    assign current_mode = (state_q == ARB_ACTIVE) ? grant_q + 1'b1 : '0;
    assign in_holdoff   = (state_q == ARB_HOLDOFF);
    assign dbg_state_o  = state_q;

    assign sdram_inputAddress = sd_addr_q;
    assign sdram_writeData    = sd_wdata_q;
    assign sdram_isWriting    = sd_wr_q;
    assign sdram_inputValid   = sd_valid_q;

    music_box_audio_mixer #(
        .NUM_MODES     (NUM_MODES),
        .AUDIO_W       (AUDIO_W),
        .PASSTHRU_MASK (PASSTHRU_MASK)
    ) u_mixer (
        .clk_i    (clock_50Mhz),
        .rst_i    (reset),
        .enable_i (mode_enable),
        .audio_i  (mode_audio),
        .audio_o  (audio_out)
    );

endmodule

// File: tb/tb_music_box_mode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_music_box_mode_arbiter
// Directed bench for the music box mode arbiter with a cycle-level
// behavioural model (active mode / holdoff countdown / armed flags) checked
// against the DUT every cycle, plus literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_music_box_mode_arbiter;
    import music_box_pkg::*;

    localparam int             NM    = 4;
    localparam int             AW    = 8;
    localparam int             HC    = 33;
    localparam int             TO    = 100;
    localparam int             REQ_REL = 1;
    localparam logic [NM-1:0]  OWNER = 4'b1100;
    localparam logic [NM-1:0]  PASS  = 4'b0001;
    localparam int             MAXA  = (1 << AW) - 1;
`ifdef MUSICBOX_MODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0]      request_n = '1;
    logic [NM-1:0]      mode_done = '0;
    logic [NM*AW-1:0]   mode_audio = '0;
    logic [NM*25-1:0]   ch_addr = '0;
    logic [NM*16-1:0]   ch_wdata = '0;
    logic [NM-1:0]      ch_is_writing = '0;
    logic [NM-1:0]      ch_valid = '0;

    logic [2:0]         current_mode;
    logic [NM-1:0]      mode_enable;
    logic               in_holdoff;
    logic               mode_timeout;
    logic [AW-1:0]      audio_out;
    logic [24:0]        sdram_inputAddress;
    logic [15:0]        sdram_writeData;
    logic               sdram_isWriting;
    logic               sdram_inputValid;
    arb_state_t         dbg_state;

    music_box_mode_arbiter #(
        .NUM_MODES        (NM),
        .AUDIO_W          (AW),
        .HOLDOFF_CYCLES   (HC),
        .REQUIRE_RELEASE  (REQ_REL),
        .SDRAM_OWNER_MASK (OWNER),
        .PASSTHRU_MASK    (PASS),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clock_50Mhz        (clk),
        .reset              (reset),
        .request_n          (request_n),
        .mode_done          (mode_done),
        .current_mode       (current_mode),
        .mode_enable        (mode_enable),
        .in_holdoff         (in_holdoff),
        .mode_timeout       (mode_timeout),
        .mode_audio         (mode_audio),
        .audio_out          (audio_out),
        .ch_addr            (ch_addr),
        .ch_wdata           (ch_wdata),
        .ch_is_writing      (ch_is_writing),
        .ch_valid           (ch_valid),
        .sdram_inputAddress (sdram_inputAddress),
        .sdram_writeData    (sdram_writeData),
        .sdram_isWriting    (sdram_isWriting),
        .sdram_inputValid   (sdram_inputValid),
        .dbg_state_o        (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks    = 0;
    int failures  = 0;
    int to_pulses = 0;
    bit cmp_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_act: index of the active mode or -1; m_hold: HOLDOFF cycles remaining.
    int            m_act = -1;
    int            m_hold = 0;
    int            m_act_cycles = 0;
    logic [NM-1:0] m_armed = '1;
    logic [24:0]   e_addr = '0;
    logic [15:0]   e_wdata = '0;
    logic          e_wr = 1'b0;
    logic          e_valid = 1'b0;
    logic [AW-1:0] e_audio = '0;
    logic          e_timeout = 1'b0;
    int            m_sum;
    int            m_pick;

    always @(posedge clk) begin
        if (reset) begin
            m_act = -1; m_hold = 0; m_act_cycles = 0; m_armed = '1;
            e_addr = '0; e_wdata = '0; e_wr = 1'b0; e_valid = 1'b0;
            e_audio = '0; e_timeout = 1'b0;
        end else begin
            // Registered outputs reflect the state/inputs before this edge.
            e_addr = '0; e_wdata = '0; e_wr = 1'b0; e_valid = 1'b0;
            if (m_act >= 0 && OWNER[m_act]) begin
                e_addr  = ch_addr[m_act*25 +: 25];
                e_wdata = ch_wdata[m_act*16 +: 16];
                e_wr    = ch_is_writing[m_act];
                e_valid = ch_valid[m_act];
            end
            m_sum = 0;
            for (int k = 0; k < NM; k++) begin
                if (m_act == k || PASS[k]) m_sum += int'(mode_audio[k*AW +: AW]);
            end
            e_audio = (m_sum > MAXA) ? AW'(MAXA) : AW'(m_sum);
            e_timeout = 1'b0;

            if (m_act >= 0) begin
                if (mode_done[m_act]) begin
                    m_act = -1; m_hold = HC;
                end else if (TO_EN && m_act_cycles + 1 == TO) begin
                    m_act = -1; m_hold = HC; e_timeout = 1'b1;
                end else begin
                    m_act_cycles++;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_pick = -1;
                for (int k = 0; k < NM; k++) begin
                    if (!request_n[k] && (m_armed[k] || REQ_REL == 0)) m_pick = k;
                end
                if (m_pick >= 0) begin
                    m_act = m_pick; m_act_cycles = 0; m_armed[m_pick] = 1'b0;
                end
            end
            for (int k = 0; k < NM; k++) begin
                if (request_n[k]) m_armed[k] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cur_mode", current_mode, (m_act < 0) ? 0 : m_act + 1);
            check("mode_en", mode_enable, (m_act < 0) ? 0 : (64'd1 << m_act));
            check("holdoff", in_holdoff, m_hold > 0);
            check("timeout", mode_timeout, e_timeout);
            check("audio", audio_out, e_audio);
            check("sd_addr", sdram_inputAddress, e_addr);
            check("sd_wdata", sdram_writeData, e_wdata);
            check("sd_wr", sdram_isWriting, e_wr);
            check("sd_valid", sdram_inputValid, e_valid);
            if (mode_timeout) to_pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        request_n[k] = 1'b0;
        tick(1);
        request_n[k] = 1'b1;
    endtask

    task automatic wait_holdoff(input string name);
        int n = 0;
        while (in_holdoff && n < 200) begin
            n++;
            tick(1);
        end
        check(name, n, HC);
    endtask

    task automatic finish_mode(input int k, input string name);
        mode_done[k] = 1'b1;
        tick(1);
        mode_done[k] = 1'b0;
        wait_holdoff(name);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        mode_audio[0*AW +: AW] = 8'h00;
        mode_audio[1*AW +: AW] = 8'h40;
        mode_audio[2*AW +: AW] = 8'h11;
        mode_audio[3*AW +: AW] = 8'h22;
        tick(3);
        cmp_en = 1'b1;
        check("rst_cur_mode", current_mode, 3'd0);
        check("rst_mode_en", mode_enable, 4'b0000);
        check("rst_audio", audio_out, 8'h00);
        check("rst_sd_valid", sdram_inputValid, 1'b0);
        reset = 1'b0;
        tick(2);

        // Single grant of mode 1; audio is mode 1 only.
        press(1);
        check("grant1_cur", current_mode, 3'd2);
        check("grant1_en", mode_enable, 4'b0010);
        tick(1);
        check("grant1_audio", audio_out, 8'h40);
        finish_mode(1, "holdoff_len_m1");
        tick(2);

        // Simultaneous 0 and 3: 3 wins; other modes' done ignored.
        request_n = 4'b0110;
        tick(1);
        check("prio_cur", current_mode, 3'd4);
        tick(3);
        mode_done[0] = 1'b1;
        tick(1);
        mode_done[0] = 1'b0;
        check("other_done_ignored", current_mode, 3'd4);
        request_n[0] = 1'b1;
        finish_mode(3, "holdoff_len_m3");
        // Mode 3 still held low: must not be re-granted.
        tick(5);
        check("no_regrant_held", current_mode, 3'd0);
        request_n[3] = 1'b1;
        tick(1);
        request_n[3] = 1'b0;
        tick(1);
        check("regrant_after_release", current_mode, 3'd4);
        request_n[3] = 1'b1;
        finish_mode(3, "holdoff_len_m3b");

        // SDRAM mux: mode 2 is an owner, mode 0 is not.
        ch_addr[2*25 +: 25]  = 25'h1ABCDE;
        ch_wdata[2*16 +: 16] = 16'hBEEF;
        ch_is_writing[2]     = 1'b1;
        ch_valid[2]          = 1'b1;
        ch_addr[0*25 +: 25]  = 25'h0123456;
        ch_valid[0]          = 1'b1;
        press(2);
        tick(2);
        check("sd_addr_m2", sdram_inputAddress, 25'h1ABCDE);
        check("sd_valid_m2", sdram_inputValid, 1'b1);
        finish_mode(2, "holdoff_len_m2");
        press(0);
        tick(3);
        check("sd_valid_m0", sdram_inputValid, 1'b0);
        check("sd_addr_m0", sdram_inputAddress, 25'h0);
        finish_mode(0, "holdoff_len_m0");

        // Saturating mix: active C0 plus passthru 80.
        mode_audio[0*AW +: AW] = 8'h80;
        mode_audio[1*AW +: AW] = 8'hC0;
        press(1);
        tick(1);
        check("audio_sat", audio_out, 8'hFF);
        finish_mode(1, "holdoff_len_sat");

        // Reset while mode 3 is active and driving SDRAM.
        ch_valid[3] = 1'b1;
        ch_addr[3*25 +: 25] = 25'h0000F0;
        press(3);
        tick(2);
        check("owner3_valid", sdram_inputValid, 1'b1);
        reset = 1'b1;
        tick(1);
        check("midrst_en", mode_enable, 4'b0000);
        check("midrst_valid", sdram_inputValid, 1'b0);
        reset = 1'b0;
        tick(2);

`ifdef MUSICBOX_MODE_TIMEOUT_EN
        begin
            int n;
            to_pulses = 0;
            press(2);
            n = 0;
            while (!in_holdoff && n < 300) begin
                n++;
                tick(1);
            end
            check("to_active_cycles", n, TO);
            wait_holdoff("holdoff_len_to");
            check("to_pulse_count", to_pulses, 1);
            to_pulses = 0;
            press(2);
            tick(TO - 1);
            mode_done[2] = 1'b1;
            tick(1);
            mode_done[2] = 1'b0;
            check("done_wins_holdoff", in_holdoff, 1'b1);
            wait_holdoff("holdoff_len_done");
            check("done_wins_no_pulse", to_pulses, 0);
        end
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
